// File: rtl/clock_generator_pkg.sv
// Shared types and constants for the clock generator slice.
package clock_generator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    localparam logic MODE_RUN  = 1'b0;
    localparam logic MODE_STEP = 1'b1;

endpackage

// File: rtl/step_conditioner.sv
// Conditions the manual step input into a one-cycle step request.
// With CLOCK_GENERATOR_STEP_SYNC_EN defined, step is synchronised through two
// flops and edge-detected with a third, giving one request per 0->1 transition
// of step, two cycles later. Otherwise step passes straight through as a
// synchronous request.
module step_conditioner (
    input  logic clk_in,
    input  logic rst,
    input  logic step,
    output logic step_req
);

`ifdef CLOCK_GENERATOR_STEP_SYNC_EN
    logic s1;
    logic s2;
    logic s3;

    // Two-flop synchroniser plus one history flop for rising-edge detection
    always_ff @(posedge clk_in) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= step;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign step_req = s2 & ~s3;
`else
    logic unused_sync;

    assign unused_sync = clk_in ^ rst;
    assign step_req    = step;
`endif

endmodule

// File: rtl/clock_generator.sv
// Runtime-programmable clock divider with RUN / STEP modes and a glitch-free
// halt. The output clock is a registered copy of the HIGH state, so every
// phase lasts exactly div_eff input cycles and is never resized or cut short
// except by rst. Optional macro: CLOCK_GENERATOR_STEP_SYNC_EN (synchronised,
// edge-detected step input; see step_conditioner).
module clock_generator
    import clock_generator_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    input  logic             mode,
    input  logic             step,
    input  logic             halt,
    output logic             clk_out,
    output logic             rise_tick,
    output logic             active
);

    localparam logic [WIDTH-1:0] DIV_RESET = DEFAULT_DIV[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] counter;
    logic [WIDTH-1:0] div_cur;
    logic [WIDTH-1:0] div_pend;
    logic             pend_valid;
    logic [WIDTH-1:0] div_eff;
    logic [WIDTH-1:0] last_count;
    logic             phase_done;
    logic             boundary;
    logic             step_req;

    step_conditioner u_step_conditioner (
        .clk_in   (clk_in),
        .rst      (rst),
        .step     (step),
        .step_req (step_req)
    );

    assign div_eff    = (div_cur == '0) ? ONE : div_cur;
    assign last_count = div_eff - ONE;
    assign phase_done = (counter == last_count);
    assign boundary   = (next_state != state);
    assign active     = (state != IDLE);

    // Decide the next phase; phases only end when the counter reaches div_eff-1
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!halt) begin
                    if (mode == MODE_RUN) begin
                        next_state = LOW;
                    end else if (step_req) begin
                        next_state = HIGH;
                    end
                end
            end
            LOW: begin
                if (phase_done) begin
                    next_state = (mode == MODE_RUN && !halt) ? HIGH : IDLE;
                end
            end
            HIGH: begin
                if (phase_done) begin
                    next_state = (mode == MODE_RUN && !halt) ? LOW : IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Phase register, phase counter and registered clock/strobe outputs
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state     <= IDLE;
            counter   <= '0;
            clk_out   <= 1'b0;
            rise_tick <= 1'b0;
        end else begin
            state <= next_state;
            if (boundary || state == IDLE) begin
                counter <= '0;
            end else begin
                counter <= counter + ONE;
            end
            clk_out   <= (next_state == HIGH);
            rise_tick <= (next_state == HIGH) && (state != HIGH);
        end
    end

    // Divisor staging: loads wait in div_pend until a phase boundary or IDLE
    always_ff @(posedge clk_in) begin
        if (rst) begin
            div_cur    <= DIV_RESET;
            div_pend   <= DIV_RESET;
            pend_valid <= 1'b0;
        end else begin
            if (pend_valid && (boundary || state == IDLE)) begin
                div_cur    <= div_pend;
                pend_valid <= 1'b0;
            end
            if (div_load) begin
                div_pend   <= div_in;
                pend_valid <= 1'b1;
            end
        end
    end

endmodule
